// File: rtl/bilstm_concat_store.sv
// bilstm_concat_store: gathers the forward and backward BiLSTM hidden-state
// streams of one sequence step into a concatenated vector
// (forward at 0..HIDDEN-1, backward at HIDDEN..2*HIDDEN-1).
// Storage is ping-pong double-buffered so FC1 can read the published bank
// while the next BiLSTM pass fills the other one.
module bilstm_concat_store #(
  parameter int HIDDEN = 64,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(2*HIDDEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_bilstm,
  input  logic              fwd_valid,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              fwd_ready,
  input  logic              bwd_valid,
  input  logic [DATA_W-1:0] bwd_data,
  output logic              bwd_ready,
  output logic              done_store_concat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_bank_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = $clog2(HIDDEN+1);
  localparam int MEM_D = 2**(ADDR_W+1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic                r_rd_bank_valid;
  logic                r_overrun;
  logic [CNT_W-1:0]    r_fwd_cnt;
  logic [CNT_W-1:0]    r_bwd_cnt;
  logic [CNT_W-1:0]    w_fwd_cnt_nxt;
  logic [CNT_W-1:0]    w_bwd_cnt_nxt;
  logic                w_fwd_ready;
  logic                w_bwd_ready;
  logic                w_fwd_wr;
  logic                w_bwd_wr;
  logic                w_clear;
  logic                w_publish;
  logic [DATA_W-1:0]   r_mem [0:MEM_D-1];
  logic [DATA_W-1:0]   r_rd_data;
  logic [ADDR_W:0]     w_fwd_waddr;
  logic [ADDR_W:0]     w_bwd_waddr;
  logic [ADDR_W:0]     w_raddr;
  logic                w_raddr_ok;

  // Decode per-state handshake, counter clear and publish strobes.
  // A start during COLLECT forces both readies low so no beat lands in that cycle.
  always_comb begin
    w_fwd_ready = 1'b0;
    w_bwd_ready = 1'b0;
    w_clear     = 1'b0;
    w_publish   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_bilstm) begin
          w_clear = 1'b1;
        end else begin
          w_clear = 1'b0;
        end
      end
      S_COLLECT: begin
        if (start_bilstm) begin
          w_clear = 1'b1;
        end else begin
          w_fwd_ready = (r_fwd_cnt < CNT_W'(HIDDEN));
          w_bwd_ready = (r_bwd_cnt < CNT_W'(HIDDEN));
        end
      end
      S_PUBLISH: begin
        w_publish = 1'b1;
        if (start_bilstm) begin
          w_clear = 1'b1;
        end else begin
          w_clear = 1'b0;
        end
      end
      default: begin
        w_clear = 1'b0;
      end
    endcase
  end

  // Accepted beats and the counter values they produce.
  always_comb begin
    w_fwd_wr      = fwd_valid && w_fwd_ready;
    w_bwd_wr      = bwd_valid && w_bwd_ready;
    w_fwd_cnt_nxt = w_clear ? '0 : (r_fwd_cnt + CNT_W'(w_fwd_wr));
    w_bwd_cnt_nxt = w_clear ? '0 : (r_bwd_cnt + CNT_W'(w_bwd_wr));
  end

  // Next-state logic; PUBLISH is entered on the edge that takes the final beat,
  // so done follows the last beat by exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_bilstm) w_state_nxt = S_COLLECT;
        else              w_state_nxt = S_IDLE;
      end
      S_COLLECT: begin
        if (!start_bilstm &&
            (w_fwd_cnt_nxt == CNT_W'(HIDDEN)) &&
            (w_bwd_cnt_nxt == CNT_W'(HIDDEN))) w_state_nxt = S_PUBLISH;
        else                                   w_state_nxt = S_COLLECT;
      end
      S_PUBLISH: begin
        if (start_bilstm) w_state_nxt = S_COLLECT;
        else              w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Write and read addresses into the two-bank store ({bank, element}).
  always_comb begin
    w_fwd_waddr = {r_wr_bank, ADDR_W'(r_fwd_cnt)};
    w_bwd_waddr = {r_wr_bank, ADDR_W'(HIDDEN) + ADDR_W'(r_bwd_cnt)};
    w_raddr     = {r_rd_bank, rd_addr};
    w_raddr_ok  = ({1'b0, rd_addr} < (ADDR_W+1)'(2*HIDDEN));
  end

  // Control state, bank pointers, overrun flag and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b1;
      r_rd_bank_valid <= 1'b0;
      r_overrun       <= 1'b0;
      r_fwd_cnt       <= '0;
      r_bwd_cnt       <= '0;
      r_rd_data       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_fwd_cnt <= w_fwd_cnt_nxt;
      r_bwd_cnt <= w_bwd_cnt_nxt;
      r_overrun <= (r_state == S_COLLECT) && start_bilstm;
      if (w_publish) begin
        r_rd_bank       <= r_wr_bank;
        r_wr_bank       <= ~r_wr_bank;
        r_rd_bank_valid <= 1'b1;
      end else begin
        r_rd_bank       <= r_rd_bank;
        r_wr_bank       <= r_wr_bank;
        r_rd_bank_valid <= r_rd_bank_valid;
      end
      if (rd_en) begin
        r_rd_data <= w_raddr_ok ? r_mem[w_raddr] : '0;
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  // Bank storage: forward and backward halves never share an address.
  always_ff @(posedge clk) begin
    if (w_fwd_wr) r_mem[w_fwd_waddr] <= fwd_data;
    if (w_bwd_wr) r_mem[w_bwd_waddr] <= bwd_data;
  end

  assign fwd_ready         = w_fwd_ready;
  assign bwd_ready         = w_bwd_ready;
  assign done_store_concat = (r_state == S_PUBLISH);
  assign busy              = (r_state == S_COLLECT);
  assign overrun           = r_overrun;
  assign rd_data           = r_rd_data;
  assign rd_bank_valid     = r_rd_bank_valid;

endmodule
